// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 4:1 N-bit mux feeding one valid/ready port.
// Optional burst lock (several beats per grant) is enabled by defining ARB_BURST_LOCK_EN.
module mux4_rr_arbiter #(
   parameter int N         = 4,
   parameter int MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   req,
   input  logic [N-1:0] i0,
   input  logic [N-1:0] i1,
   input  logic [N-1:0] i2,
   input  logic [N-1:0] i3,
   input  logic         out_ready,
   output logic [N-1:0] y,
   output logic         out_valid,
   output logic [1:0]   sel,
   output logic [3:0]   gnt,
   output logic [3:0]   ack
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state;
   logic [1:0] ptr;
   logic [1:0] rot_ptr;
   logic [1:0] arb_ptr;
   logic [1:0] win;
   logic       win_vld;
   logic       xfer;
   logic       hold;
   logic       release_gnt;

   assign out_valid   = (state == GRANT) && req[sel];
   assign xfer        = out_valid && out_ready;
   assign ack         = gnt & {4{xfer}};
   assign release_gnt = (xfer && !hold) || !req[sel];

   always_comb begin
      case (sel)
         2'd0:    y = i0;
         2'd1:    y = i1;
         2'd2:    y = i2;
         default: y = i3;
      endcase
   end

   // While granted, arbitrate as if ptr had already moved past the holder,
   // so the next winner is ready on the same edge the grant is released.
   always_comb begin
      rot_ptr = sel + 2'd1;
      arb_ptr = (state == GRANT) ? rot_ptr : ptr;
      win_vld = 1'b0;
      win     = arb_ptr;
      for (int j = 3; j >= 0; j--) begin
         if (req[arb_ptr + 2'(j)]) begin
            win_vld = 1'b1;
            win     = arb_ptr + 2'(j);
         end
      end
   end

`ifdef ARB_BURST_LOCK_EN
   logic [7:0] cnt;

   assign hold = xfer && (cnt < 8'(MAX_BURST - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= 8'd0;
      else if (state == GRANT) begin
         if (hold)
            cnt <= cnt + 8'd1;
         else if (release_gnt)
            cnt <= 8'd0;
      end
   end
`else
   assign hold = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sel   <= 2'd0;
         gnt   <= 4'd0;
         ptr   <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  state <= GRANT;
                  sel   <= win;
                  gnt   <= 4'b0001 << win;
               end
            end
            GRANT: begin
               if (release_gnt) begin
                  ptr <= rot_ptr;
                  if (win_vld) begin
                     sel <= win;
                     gnt <= 4'b0001 << win;
                  end else begin
                     state <= IDLE;
                     gnt   <= 4'd0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural round-robin model.
module tb_mux4_rr_arbiter;
   localparam int N         = 4;
   localparam int MAX_BURST = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [N-1:0] wd [4];
   logic         out_ready;
   logic [N-1:0] y;
   logic         out_valid;
   logic [1:0]   sel;
   logic [3:0]   gnt;
   logic [3:0]   ack;

   int n_chk  = 0;
   int n_pass = 0;

   mux4_rr_arbiter #(.N(N), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst), .req(req),
      .i0(wd[0]), .i1(wd[1]), .i2(wd[2]), .i3(wd[3]),
      .out_ready(out_ready), .y(y), .out_valid(out_valid),
      .sel(sel), .gnt(gnt), .ack(ack)
   );

   always #5 clk = ~clk;

   // model: whether a grant is held, by whom, rotation pointer, beats so far
   bit       m_busy;
   int       m_sel;
   int       m_ptr;
   int       m_cnt;
   logic [3:0] last_ack;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int winner(input logic [3:0] r, input int p);
      for (int j = 0; j < 4; j++)
         if (r[(p + j) % 4]) return (p + j) % 4;
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; last_ack = 4'b0;
   endtask

   // check all outputs against the model, then advance the model and clock one cycle
   task automatic cyc();
      logic [3:0]   eg, ea;
      logic         eov;
      logic [N-1:0] ey;
      bit           burst;
      int           w;
      #1;
      eg  = m_busy ? 4'(1 << m_sel) : 4'b0;
      eov = m_busy && req[m_sel];
      ea  = (eov && out_ready) ? eg : 4'b0;
      ey  = wd[m_sel];
      check("gnt", gnt, eg);
      check("sel", sel, m_sel);
      check("out_valid", out_valid, eov);
      check("ack", ack, ea);
      check("y", y, ey);
      last_ack = ea;
`ifdef ARB_BURST_LOCK_EN
      burst = 1;
`else
      burst = 0;
`endif
      if (!m_busy) begin
         w = winner(req, m_ptr);
         if (w >= 0) begin m_busy = 1; m_sel = w; end
      end else if (ea != 0 && burst && m_cnt < MAX_BURST - 1) begin
         m_cnt++;
      end else if (ea != 0 || !req[m_sel]) begin
         m_ptr = (m_sel + 1) % 4;
         m_cnt = 0;
         w = winner(req, m_ptr);
         if (w >= 0) m_sel = w;
         else m_busy = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 4'b0;
      #1;
      check("rst_gnt", gnt, 4'b0);
      check("rst_ov", out_valid, 1'b0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [N-1:0] fair_seq [5];
      fair_seq[0] = 4'b0001; fair_seq[1] = 4'b0010; fair_seq[2] = 4'b0100;
      fair_seq[3] = 4'b1000; fair_seq[4] = 4'b0001;
      wd[0] = 4'b0001; wd[1] = 4'b0010; wd[2] = 4'b0100; wd[3] = 4'b1000;
      rst = 1'b1; req = 4'b1111; out_ready = 1'b0;
      model_reset();
      #3;
      check("reset_gnt", gnt, 4'b0);
      check("reset_ov", out_valid, 1'b0);
      check("reset_sel", sel, 2'd0);
      check("reset_y", y, 4'b0001);
      @(negedge clk);
      rst = 1'b0;
      cyc();
      check("first_gnt", gnt, 4'b0001);
      check("first_y", y, 4'b0001);

      // fairness under full load
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
`ifndef ARB_BURST_LOCK_EN
         check("fair_y", y, fair_seq[k]);
`endif
         cyc();
      end

      // single requester keeps its grant each cycle
      @(negedge clk);
      do_reset();
      req = 4'b0100; out_ready = 1'b1;
      cyc();
      for (int k = 0; k < 3; k++) begin
         #1;
         check("single_sel", sel, 2'd2);
         check("single_ack", ack, 4'b0100);
         check("single_y", y, 4'b0100);
         cyc();
      end

      // backpressure then one acknowledged beat
      do_reset();
      req = 4'b0010; out_ready = 1'b0;
      cyc();
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_y", y, 4'b0010);
         check("bp_ov", out_valid, 1'b1);
         check("bp_ack", ack, 4'b0);
         cyc();
      end
      out_ready = 1'b1;
      #1 check("bp_ack_hi", ack, 4'b0010);
      cyc();
      req = 4'b0;
      #1 check("bp_ack_lo", ack, 4'b0);
      cyc();

      // withdraw: holder 3 drops, requester 0 takes over with no ack
      do_reset();
      req = 4'b1000; out_ready = 1'b0;
      cyc();
      check("wd_sel3", sel, 2'd3);
      req = 4'b0001;
      #1 check("wd_noack", ack, 4'b0);
      cyc();
      check("wd_sel0", sel, 2'd0);

`ifdef ARB_BURST_LOCK_EN
      do_reset();
      req = 4'b0011; out_ready = 1'b1;
      cyc();
      for (int k = 0; k < 16; k++) begin
         #1 check("burst_ack", ack, ((k / 4) % 2) ? 4'b0010 : 4'b0001);
         cyc();
      end
`endif

      // randomized traffic; requesters hold data until acked or withdrawn
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(99) == 0) begin
            do_reset();
         end else begin
            for (int k = 0; k < 4; k++) begin
               if (req[k] && !last_ack[k]) begin
                  if ($urandom_range(9) == 0) req[k] = 1'b0;
               end else begin
                  req[k] = 1'($urandom_range(1));
                  wd[k]  = N'($urandom);
               end
            end
            out_ready = ($urandom_range(3) != 0);
            cyc();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one N-bit 4:1 multiplexer among four requesters and delivers the winner's word to a single valid/ready output. It owns the mux select. Requesters present a request and a data word. The arbiter picks one with rotating priority, holds the grant until the word is accepted or withdrawn, and then rotates. It sits between four producer blocks and one shared consumer.

## Interface
- N, 4, data width of each input word and of y
- MAX_BURST, 4, maximum beats held by one grant; used only when ARB_BURST_LOCK_EN is defined; legal range 1..255
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  4  req[k] high = requester k has a word on ik
- i0, i1, i2, i3  input  N  requester data words
- out_ready  input  1  consumer accepts y this cycle
- y  output  N  selected word: ik where k = sel
- out_valid  output  1  y is valid
- sel  output  2  registered mux select (current grant index)
- gnt  output  4  registered one-hot grant; all-zero when idle
- ack  output  4  one-hot transfer pulse to the granted requester

## Operation
- States: IDLE (gnt=0) and GRANT (gnt=one-hot of sel).
- Combinational outputs:
  - y = mux(i0..i3, sel), always, including in IDLE.
  - out_valid = GRANT & req[sel].
  - ack[k] = gnt[k] & out_valid & out_ready.
- Priority pointer ptr (2 bits, internal):
  - Winner = first k with req[k]=1 scanning ptr, ptr+1, ptr+2, ptr+3, mod 4.
- IDLE, any req high: next cycle GRANT, sel = winner.
- IDLE, no req: stay IDLE; sel holds its last value.
- GRANT, transfer (out_valid & out_ready):
  - Set ptr <= sel+1 mod 4.
  - Re-arbitrate in the same cycle with the updated ptr. The current holder therefore has lowest priority.
  - Next cycle: GRANT to the winner, or IDLE if no req is high.
  - Back-to-back grants have no bubble.
- GRANT, req[sel] low (withdraw):
  - Set ptr <= sel+1 mod 4 and re-arbitrate as above. No ack is issued.
- A requester whose req stays high after ack is treated as a new request.
- Requesters hold ik stable while req[k]=1 and no ack has been received.

## Timing
- Reset (asynchronous, immediate): state=IDLE, sel=0, gnt=0, ptr=0, beat count=0.
  - Hence out_valid=0, ack=0, y=i0.
- Latency: req rising in IDLE gives out_valid=1 on the following cycle (1 clk).
- Throughput: one word per clk when out_ready stays high and requests are pending.
- Simultaneous requests are resolved by ptr only. After reset, ptr=0, so requester 0 wins the first tie.
- out_ready is don't-care while out_valid=0.
- Reset asserted mid-grant drops the grant at once. The in-flight word is not acknowledged.
- Wrap-around: ptr after sel=3 is 0.

## Configuration
- ARB_BURST_LOCK_EN defined:
  - An internal beat counter counts transfers under the current grant.
  - On a transfer with count < MAX_BURST-1, the grant stays on sel, count increments, and ptr is unchanged.
  - On the MAX_BURST-th transfer, or on withdraw, the arbiter rotates as in Operation and count resets to 0.
- ARB_BURST_LOCK_EN undefined: no counter exists; every transfer rotates.

## Test plan
- Reset then idle:
  - rst high with req=4'b1111 -> gnt=0, out_valid=0, sel=0, y=i0.
  - Release rst -> next cycle gnt=4'b0001, y=i0.
- Single requester: req=4'b0100, i2=4'b0100, out_ready=1 -> one cycle later sel=2, out_valid=1, y=4'b0100, ack=4'b0100. The grant persists each cycle while req[2] stays high.
- Fairness with macro undefined: req=4'b1111 held, out_ready=1, i0..i3=0001/0010/0100/1000 -> y sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- Backpressure: grant on requester 1, out_ready=0 for 3 cycles -> y=4'b0010 and out_valid=1 held, ack=0. Raise out_ready -> ack=4'b0010 for exactly 1 cycle.
- Withdraw: requester 3 granted; drop req[3] before out_ready with req[0] pending -> no ack; next cycle sel=0.
- Burst with ARB_BURST_LOCK_EN and MAX_BURST=4: req=4'b0011, out_ready=1 -> four consecutive acks to requester 0, then four to requester 1, repeating.
